// File: rtl/rf_wr_arbiter.sv
// Two-requester arbiter for the single register-file write port.
// Each requester owns a 1-entry hold; pending holds are granted oldest-first, round-robin on ties.
module rf_wr_arbiter #(
    parameter int DW = 16,
    parameter int AW = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          a_valid,
    input  logic [AW-1:0] a_reg,
    input  logic [DW-1:0] a_data,
    output logic          a_ready,
    input  logic          b_valid,
    input  logic [AW-1:0] b_reg,
    input  logic [DW-1:0] b_data,
    output logic          b_ready,
    output logic          write,
    output logic [AW-1:0] writeregsel,
    output logic [DW-1:0] writedata,
    output logic          err
);

    // hold stage: control (reset) and payload (not reset)
    logic          vld_a_p0, vld_b_p0;
    logic          age_a_p0, age_b_p0;
    logic          rr_p0;
    logic          err_p0;
    logic [AW-1:0] reg_a_p0, reg_b_p0;
    logic [DW-1:0] data_a_p0, data_b_p0;

    logic pick_a, grant_a, grant_b;
    logic load_a, load_b, keep_a, keep_b;

    // age bit = younger entry; equal age bits mean both loaded on the same edge
    always_comb begin
        pick_a = 1'b1;
        if (age_a_p0 != age_b_p0)
            pick_a = ~age_a_p0;
        else if (reg_a_p0 == reg_b_p0)
            pick_a = 1'b1;
        else
            pick_a = ~rr_p0;
    end

    assign grant_a = vld_a_p0 & (~vld_b_p0 | pick_a);
    assign grant_b = vld_b_p0 & ~grant_a;

    assign a_ready = ~vld_a_p0 | grant_a;
    assign b_ready = ~vld_b_p0 | grant_b;
    assign load_a  = a_valid & a_ready;
    assign load_b  = b_valid & b_ready;
    assign keep_a  = vld_a_p0 & ~grant_a;
    assign keep_b  = vld_b_p0 & ~grant_b;

    assign write       = grant_a | grant_b;
    assign writeregsel = grant_a ? reg_a_p0  : (grant_b ? reg_b_p0  : '0);
    assign writedata   = grant_a ? data_a_p0 : (grant_b ? data_b_p0 : '0);
    assign err         = err_p0;

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_a_p0 <= 1'b0;
            vld_b_p0 <= 1'b0;
            age_a_p0 <= 1'b0;
            age_b_p0 <= 1'b0;
            rr_p0    <= 1'b0;
            err_p0   <= 1'b0;
        end else begin
            vld_a_p0 <= load_a | keep_a;
            vld_b_p0 <= load_b | keep_b;
            if (load_a && load_b) begin
                age_a_p0 <= 1'b0;
                age_b_p0 <= 1'b0;
            end else if (load_a) begin
                age_a_p0 <= keep_b;
                age_b_p0 <= 1'b0;
            end else if (load_b) begin
                age_b_p0 <= keep_a;
                age_a_p0 <= 1'b0;
            end
            // rr names the loser of a both-full grant (0 = A, 1 = B)
            if (vld_a_p0 && vld_b_p0)
                rr_p0 <= grant_a;
            err_p0 <= load_a & load_b & (a_reg == b_reg);
        end
    end

    always_ff @(posedge clk) begin
        if (load_a) begin
            reg_a_p0  <= a_reg;
            data_a_p0 <= a_data;
        end
        if (load_b) begin
            reg_b_p0  <= b_reg;
            data_b_p0 <= b_data;
        end
    end

endmodule

// File: tb/tb_rf_wr_arbiter.sv
// Self-checking bench for rf_wr_arbiter: directed scenarios plus a randomized run
// against a stamp-ordered reference model of the two holds.
module tb_rf_wr_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        a_valid, b_valid;
    logic [2:0]  a_reg, b_reg;
    logic [15:0] a_data, b_data;
    logic        a_ready, b_ready;
    logic        write;
    logic [2:0]  writeregsel;
    logic [15:0] writedata;
    logic        err;

    int npass  = 0;
    int ntotal = 0;

    logic [15:0] rf_mirror [8];

    rf_wr_arbiter #(.DW(16), .AW(3)) dut (
        .clk(clk), .rst(rst),
        .a_valid(a_valid), .a_reg(a_reg), .a_data(a_data), .a_ready(a_ready),
        .b_valid(b_valid), .b_reg(b_reg), .b_data(b_data), .b_ready(b_ready),
        .write(write), .writeregsel(writeregsel), .writedata(writedata), .err(err)
    );

    always #5 clk = ~clk;

    always @(posedge clk)
        if (write === 1'b1) rf_mirror[writeregsel] <= writedata;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
        $fatal(1);
    end

    // drive one cycle of inputs, then observe the state after the edge
    task automatic cycle(input logic av, input logic [2:0] ar, input logic [15:0] ad,
                         input logic bv, input logic [2:0] br, input logic [15:0] bd);
        a_valid = av; a_reg = ar; a_data = ad;
        b_valid = bv; b_reg = br; b_data = bd;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        cycle(1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 16'h0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            cycle(1'b1, 3'(i + 1), 16'hDEAD, 1'b1, 3'(i + 4), 16'hCAFE);
            ntotal++; if (write !== 1'b0) $display("FAIL reset_write: got %b required 0", write); else npass++;
            ntotal++; if (err !== 1'b0) $display("FAIL reset_err: got %b required 0", err); else npass++;
            ntotal++; if (a_ready !== 1'b1 || b_ready !== 1'b1)
                $display("FAIL reset_ready: got a=%b b=%b required 1 1", a_ready, b_ready); else npass++;
            ntotal++; if (writeregsel !== 3'd0 || writedata !== 16'h0)
                $display("FAIL reset_bus: got sel=%0d data=%h required 0 0000", writeregsel, writedata); else npass++;
        end
        rst = 1'b0;
        idle();
        ntotal++; if (write !== 1'b0) $display("FAIL reset_discard: got write=%b required 0", write); else npass++;
    endtask

    task automatic test_single_a();
        do_reset();
        cycle(1'b1, 3'd3, 16'hBEEF, 1'b0, 3'd0, 16'h0);
        ntotal++; if (write !== 1'b1 || writeregsel !== 3'd3 || writedata !== 16'hBEEF)
            $display("FAIL single_a: got w=%b sel=%0d data=%h required 1 3 beef", write, writeregsel, writedata); else npass++;
        idle();
        ntotal++; if (write !== 1'b0) $display("FAIL single_a_done: got write=%b required 0", write); else npass++;
    endtask

    task automatic test_contention();
        do_reset();
        cycle(1'b1, 3'd1, 16'h1111, 1'b1, 3'd2, 16'h2222);
        ntotal++; if (write !== 1'b1 || writeregsel !== 3'd1 || writedata !== 16'h1111)
            $display("FAIL contention_first: got w=%b sel=%0d data=%h required 1 1 1111", write, writeregsel, writedata); else npass++;
        ntotal++; if (a_ready !== 1'b1 || b_ready !== 1'b0 || err !== 1'b0)
            $display("FAIL contention_ready: got a=%b b=%b err=%b required 1 0 0", a_ready, b_ready, err); else npass++;
        idle();
        ntotal++; if (write !== 1'b1 || writeregsel !== 3'd2 || writedata !== 16'h2222)
            $display("FAIL contention_second: got w=%b sel=%0d data=%h required 1 2 2222", write, writeregsel, writedata); else npass++;
        idle();
        ntotal++; if (write !== 1'b0) $display("FAIL contention_done: got write=%b required 0", write); else npass++;
    endtask

    task automatic test_collision();
        do_reset();
        cycle(1'b1, 3'd5, 16'hAAAA, 1'b1, 3'd5, 16'h5555);
        ntotal++; if (err !== 1'b1) $display("FAIL collision_err: got %b required 1", err); else npass++;
        ntotal++; if (write !== 1'b1 || writeregsel !== 3'd5 || writedata !== 16'hAAAA)
            $display("FAIL collision_first: got w=%b sel=%0d data=%h required 1 5 aaaa", write, writeregsel, writedata); else npass++;
        idle();
        ntotal++; if (err !== 1'b0) $display("FAIL collision_err_pulse: got %b required 0", err); else npass++;
        ntotal++; if (write !== 1'b1 || writeregsel !== 3'd5 || writedata !== 16'h5555)
            $display("FAIL collision_second: got w=%b sel=%0d data=%h required 1 5 5555", write, writeregsel, writedata); else npass++;
        idle();
        ntotal++; if (rf_mirror[5] !== 16'h5555) $display("FAIL collision_rf: got r5=%h required 5555", rf_mirror[5]); else npass++;
    endtask

    task automatic test_streaming();
        do_reset();
        for (int i = 0; i < 8; i++) begin
            ntotal++; if (a_ready !== 1'b1) $display("FAIL stream_ready: got %b required 1 at beat %0d", a_ready, i); else npass++;
            cycle(1'b1, 3'(i), 16'h0100 + 16'(i), 1'b0, 3'd0, 16'h0);
            ntotal++; if (write !== 1'b1 || writeregsel !== 3'(i) || writedata !== 16'h0100 + 16'(i))
                $display("FAIL stream_write: got w=%b sel=%0d data=%h required 1 %0d %h",
                         write, writeregsel, writedata, i, 16'h0100 + 16'(i)); else npass++;
        end
        idle();
        ntotal++; if (write !== 1'b0) $display("FAIL stream_done: got write=%b required 0", write); else npass++;
    endtask

    task automatic test_age();
        do_reset();
        cycle(1'b0, 3'd0, 16'h0, 1'b1, 3'd4, 16'h0001);
        cycle(1'b1, 3'd4, 16'h0002, 1'b0, 3'd0, 16'h0);
        ntotal++; if (writeregsel !== 3'd4 || writedata !== 16'h0002)
            $display("FAIL age_second: got sel=%0d data=%h required 4 0002", writeregsel, writedata); else npass++;
        idle();
        ntotal++; if (rf_mirror[4] !== 16'h0002) $display("FAIL age_rf: got r4=%h required 0002", rf_mirror[4]); else npass++;
        // B left waiting from a same-edge pair must beat a fresh A
        do_reset();
        cycle(1'b1, 3'd1, 16'h0011, 1'b1, 3'd2, 16'h0022);
        cycle(1'b1, 3'd3, 16'h0033, 1'b0, 3'd0, 16'h0);
        ntotal++; if (write !== 1'b1 || writeregsel !== 3'd2 || writedata !== 16'h0022)
            $display("FAIL age_older_b: got w=%b sel=%0d data=%h required 1 2 0022", write, writeregsel, writedata); else npass++;
        idle();
        ntotal++; if (write !== 1'b1 || writeregsel !== 3'd3 || writedata !== 16'h0033)
            $display("FAIL age_young_a: got w=%b sel=%0d data=%h required 1 3 0033", write, writeregsel, writedata); else npass++;
        idle();
    endtask

    task automatic test_random();
        logic        mfa, mfb, mrr, merr;
        logic [2:0]  ra, rb;
        logic [15:0] da, db;
        int          sa, sb;
        logic [15:0] rfm [8];
        logic        rfw [8];
        logic        pa, ga, gb, ew, ear, ebr, av, bv, la, lb;
        logic [2:0]  esel, ar, br;
        logic [15:0] edata, ad, bd;
        int          nfail_before;
        do_reset();
        mfa = 0; mfb = 0; mrr = 0; merr = 0;
        ra = 0; rb = 0; da = 0; db = 0; sa = 0; sb = 0;
        for (int k = 0; k < 8; k++) rfw[k] = 1'b0;
        nfail_before = ntotal - npass;
        for (int i = 0; i < 500; i++) begin
            // older stamp wins; same-edge pair: same register -> A, else rr
            pa = (sa < sb) || (sa == sb && (ra == rb || mrr == 1'b0));
            ga = mfa && (!mfb || pa);
            gb = mfb && !ga;
            ew = ga || gb;
            esel  = ga ? ra : (gb ? rb : 3'd0);
            edata = ga ? da : (gb ? db : 16'h0);
            ear = !mfa || ga;
            ebr = !mfb || gb;
            ntotal++; if (write !== ew) $display("FAIL rand_write c%0d: got %b required %b", i, write, ew); else npass++;
            ntotal++; if (writeregsel !== esel) $display("FAIL rand_sel c%0d: got %0d required %0d", i, writeregsel, esel); else npass++;
            ntotal++; if (writedata !== edata) $display("FAIL rand_data c%0d: got %h required %h", i, writedata, edata); else npass++;
            ntotal++; if (a_ready !== ear || b_ready !== ebr)
                $display("FAIL rand_ready c%0d: got a=%b b=%b required %b %b", i, a_ready, b_ready, ear, ebr); else npass++;
            ntotal++; if (err !== merr) $display("FAIL rand_err c%0d: got %b required %b", i, err, merr); else npass++;
            if (ew) begin rfm[esel] = edata; rfw[esel] = 1'b1; end
            av = (i < 480) && ($urandom_range(0, 9) < 7);
            bv = (i < 480) && ($urandom_range(0, 9) < 6);
            ar = 3'($urandom_range(0, 7)); br = 3'($urandom_range(0, 3));
            ad = 16'($urandom); bd = 16'($urandom);
            la = av && ear;
            lb = bv && ebr;
            if (mfa && mfb) mrr = ga;
            merr = la && lb && (ar == br);
            mfa = la || (mfa && !ga);
            mfb = lb || (mfb && !gb);
            if (la) begin ra = ar; da = ad; sa = i; end
            if (lb) begin rb = br; db = bd; sb = i; end
            cycle(av, ar, ad, bv, br, bd);
        end
        for (int k = 0; k < 8; k++)
            if (rfw[k]) begin
                ntotal++; if (rf_mirror[k] !== rfm[k])
                    $display("FAIL rand_rf r%0d: got %h required %h", k, rf_mirror[k], rfm[k]); else npass++;
            end
    endtask

    initial begin
        rst = 1'b1;
        a_valid = 0; a_reg = 0; a_data = 0;
        b_valid = 0; b_reg = 0; b_data = 0;
        test_reset();
        test_single_a();
        test_contention();
        test_collision();
        test_streaming();
        test_age();
        test_random();
        $display("%0d/%0d checks passed", npass, ntotal);
        $finish;
    end

endmodule
